dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data memory between the CPU control unit (port 0) and the program/data loader or debug port (port 1). It grants at most one access per cycle with round-robin fairness. It supports a bounded lock so one port can perform uninterrupted read-modify-write sequences. Read data returns one cycle after the grant and is steered back to the granted port.

---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for a single-ported data memory, with a bounded
// lock so one port can run uninterrupted read-modify-write sequences.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req_i,
    input  logic          p0_we_i,
    input  logic          p0_lock_i,
    input  logic [AW-1:0] p0_addr_i,
    input  logic [DW-1:0] p0_wdata_i,
    output logic          p0_gnt_o,
    output logic          p0_rvalid_o,
    output logic [DW-1:0] p0_rdata_o,
    input  logic          p1_req_i,
    input  logic          p1_we_i,
    input  logic          p1_lock_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [DW-1:0] p1_wdata_i,
    output logic          p1_gnt_o,
    output logic          p1_rvalid_o,
    output logic [DW-1:0] p1_rdata_o,
    output logic [AW-1:0] m_addr_o,
    output logic          m_rd_o,
    output logic          m_wr_o,
    output logic [DW-1:0] m_wdata_o,
    input  logic [DW-1:0] m_rdata_i,
    output logic [1:0]    state_o
);
    // Handshake: a port holds req and its command stable until it sees gnt=1
    // in the same cycle; gnt is combinational and the access happens that cycle.
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

    localparam int LCW = $clog2(MAX_LOCK + 1);
    localparam logic [LCW-1:0] LAST_CNT = LCW'(MAX_LOCK - 1);

    state_e         state_q, state_d;
    logic           prio_q, prio_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic [1:0]     rvalid_q, rvalid_d;
    logic           gnt0, gnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            lock_cnt_q <= '0;
            rvalid_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= rvalid_d;
        end
    end

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_d    = state_q;
        prio_d     = prio_q;
        lock_cnt_d = lock_cnt_q;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (p0_req_i && (!p1_req_i || !prio_q)) gnt0 = 1'b1;
                    else if (p1_req_i)                      gnt1 = 1'b1;
                    // Entering a lock counts this grant as the first locked one.
                    if (gnt0) begin
                        if (p0_lock_i) begin
                            state_d    = OWN0;
                            lock_cnt_d = LCW'(1);
                        end else begin
                            prio_d = 1'b1;
                        end
                    end
                    if (gnt1) begin
                        if (p1_lock_i) begin
                            state_d    = OWN1;
                            lock_cnt_d = LCW'(1);
                        end else begin
                            prio_d = 1'b0;
                        end
                    end
                end
                OWN0: begin
                    gnt0 = p0_req_i;
                    if (gnt0) lock_cnt_d = lock_cnt_q + LCW'(1);
                    if (!p0_lock_i || (gnt0 && lock_cnt_q == LAST_CNT)) begin
                        state_d    = IDLE;
                        prio_d     = 1'b1;
                        lock_cnt_d = '0;
                    end
                end
                OWN1: begin
                    gnt1 = p1_req_i;
                    if (gnt1) lock_cnt_d = lock_cnt_q + LCW'(1);
                    if (!p1_lock_i || (gnt1 && lock_cnt_q == LAST_CNT)) begin
                        state_d    = IDLE;
                        prio_d     = 1'b0;
                        lock_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        m_addr_o  = '0;
        m_wdata_o = '0;
        m_rd_o    = 1'b0;
        m_wr_o    = 1'b0;
        if (gnt0) begin
            m_addr_o  = p0_addr_i;
            m_wdata_o = p0_wdata_i;
            m_rd_o    = !p0_we_i;
            m_wr_o    = p0_we_i;
        end else if (gnt1) begin
            m_addr_o  = p1_addr_i;
            m_wdata_o = p1_wdata_i;
            m_rd_o    = !p1_we_i;
            m_wr_o    = p1_we_i;
        end
    end

    assign rvalid_d    = {gnt1 & ~p1_we_i, gnt0 & ~p0_we_i};
    assign p0_gnt_o    = gnt0;
    assign p1_gnt_o    = gnt1;
    // A read in flight when rst arrives never reports back.
    assign p0_rvalid_o = rvalid_q[0] & ~rst;
    assign p1_rvalid_o = rvalid_q[1] & ~rst;
    assign p0_rdata_o  = m_rdata_i;
    assign p1_rdata_o  = m_rdata_i;
    assign state_o     = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then randomized traffic, all
// checked every cycle against a behavioural arbitration/memory model.
module tb_dmem_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MAX_LOCK = 8;

    logic          clk, rst, load;
    logic [1:0]    req, we, lk;
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, m_rd, m_wr;
    logic [DW-1:0] p0_rdata, p1_rdata, m_wdata, m_rdata;
    logic [AW-1:0] m_addr;
    logic [1:0]    state;

    int checks = 0;
    int fails  = 0;

    // behavioural model
    logic [DW-1:0] init_mem [256];
    logic [DW-1:0] mem      [256];
    logic [DW-1:0] ref_mem  [256];
    logic [DW-1:0] exp_q [$];
    int            own, nl, prio;
    bit   [1:0]    rv_r;
    bit   [1:0]    og;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .p0_req_i(req[0]), .p0_we_i(we[0]), .p0_lock_i(lk[0]),
        .p0_addr_i(ad[0]), .p0_wdata_i(wd[0]),
        .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
        .p1_req_i(req[1]), .p1_we_i(we[1]), .p1_lock_i(lk[1]),
        .p1_addr_i(ad[1]), .p1_wdata_i(wd[1]),
        .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
        .m_addr_o(m_addr), .m_rd_o(m_rd), .m_wr_o(m_wr), .m_wdata_o(m_wdata),
        .m_rdata_i(m_rdata), .state_o(state)
    );

    // clock / memory block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
        else if (m_wr) mem[m_addr] <= m_wdata;
        if (m_rd) m_rdata <= mem[m_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_port(input int n, input bit r, input bit w, input bit l,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[n] = r; we[n] = w; lk[n] = l; ad[n] = a; wd[n] = d;
    endtask

    // One clock: check all outputs at negedge, then advance the model at posedge.
    task automatic cycle();
        int w;
        logic [DW-1:0] e;
        @(negedge clk);
        if (rst) w = -1;
        else if (own < 0) begin
            if (req[0] && req[1]) w = prio;
            else if (req[0])      w = 0;
            else if (req[1])      w = 1;
            else                  w = -1;
        end else w = req[own] ? own : -1;
        og = {p1_gnt, p0_gnt};
        check("gnt0", 32'(p0_gnt), 32'(w == 0));
        check("gnt1", 32'(p1_gnt), 32'(w == 1));
        check("m_rd", 32'(m_rd), 32'(w >= 0 && !we[w]));
        check("m_wr", 32'(m_wr), 32'(w >= 0 && we[w]));
        check("m_addr", 32'(m_addr), (w >= 0) ? 32'(ad[w]) : 32'd0);
        check("m_wdata", 32'(m_wdata), (w >= 0) ? 32'(wd[w]) : 32'd0);
        check("rvalid0", 32'(p0_rvalid), 32'(rv_r[0] && !rst));
        check("rvalid1", 32'(p1_rvalid), 32'(rv_r[1] && !rst));
        if (!rst) check("state", 32'(state), 32'(own + 1));
        if (rv_r != 2'b00) begin
            if (exp_q.size() == 0) check("exp_q_empty", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                if (!rst) check("rdata", rv_r[0] ? 32'(p0_rdata) : 32'(p1_rdata), 32'(e));
            end
        end
        @(posedge clk);
        rv_r = 2'b00;
        if (rst) begin
            own = -1; nl = 0; prio = 0;
            exp_q.delete();
        end else begin
            if (w >= 0) begin
                if (!we[w]) begin
                    rv_r[w] = 1'b1;
                    exp_q.push_back(ref_mem[ad[w]]);
                end else ref_mem[ad[w]] = wd[w];
            end
            if (own < 0) begin
                if (w >= 0) begin
                    if (lk[w]) begin own = w; nl = 1; end
                    else prio = 1 - w;
                end
            end else begin
                if (w == own) nl++;
                if (!lk[own] || nl == MAX_LOCK) begin
                    prio = 1 - own; own = -1; nl = 0;
                end
            end
        end
        #1;
    endtask

    logic [DW-1:0] old5;

    initial begin
        for (int i = 0; i < 256; i++) init_mem[i] = DW'($urandom);
        init_mem[8'h10] = 16'h1234;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_mem[i];
        own = -1; nl = 0; prio = 0; rv_r = 2'b00; og = 2'b00;
        req = 2'b11; we = 2'b00; lk = 2'b11;
        ad[0] = 8'h01; ad[1] = 8'h02; wd[0] = '0; wd[1] = '0;
        rst = 1'b1; load = 1'b1;
        repeat (2) @(posedge clk);
        #1 load = 1'b0;
        cycle();                       // requests held high during rst: no grant
        rst = 1'b0;
        set_port(1, 0, 0, 0, 8'h00, 16'h0);

        // single read returns one cycle later
        set_port(0, 1, 0, 0, 8'h10, 16'h0);
        cycle();
        check("t1_og0", 32'(og[0]), 32'd1);
        check("t1_rvalid0", 32'(p0_rvalid), 32'd1);
        check("t1_rdata", 32'(p0_rdata), 32'h1234);
        check("t1_rvalid1", 32'(p1_rvalid), 32'd0);
        set_port(0, 0, 0, 0, 8'h00, 16'h0);
        cycle();

        // round-robin under continuous contention
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_port(0, 1, 0, 0, AW'(8'h40 + i), 16'h0);
            set_port(1, 1, 0, 0, AW'(8'h50 + i), 16'h0);
            cycle();
            check("t2_og0", 32'(og[0]), 32'(i % 2 == 0));
            check("t2_og1", 32'(og[1]), 32'(i % 2 == 1));
        end
        set_port(1, 0, 0, 0, 8'h00, 16'h0);
        set_port(0, 1, 0, 0, 8'h33, 16'h0);
        cycle();                       // p0 unlocked grant gives p1 the next tie

        // p1 locked write burst while p0 keeps requesting
        set_port(0, 1, 0, 0, 8'h30, 16'h0);
        for (int i = 0; i < 3; i++) begin
            set_port(1, 1, 1, (i < 2), AW'(8'h20 + i), 16'hA5A5);
            cycle();
            check("t3_og1", 32'(og[1]), 32'd1);
        end
        set_port(1, 0, 0, 0, 8'h00, 16'h0);
        cycle();
        check("t3_og0", 32'(og[0]), 32'd1);
        for (int i = 0; i < 3; i++) check("t3_mem", 32'(mem[8'h20 + i]), 32'hA5A5);

        // forced release after MAX_LOCK locked grants
        set_port(0, 1, 0, 1, 8'h60, 16'h0);
        for (int i = 0; i < 12; i++) begin
            cycle();
            check("t4_og0", 32'(og[0]), 32'(i < MAX_LOCK || i > MAX_LOCK));
            check("t4_og1", 32'(og[1]), 32'(i == MAX_LOCK));
            set_port(1, 1, 0, 0, 8'h61, 16'h0);
        end
        set_port(0, 0, 0, 0, 8'h00, 16'h0);
        set_port(1, 0, 0, 0, 8'h00, 16'h0);
        cycle();

        // reset while p1 owns the memory with a read in flight
        set_port(1, 1, 0, 1, 8'h70, 16'h0);
        cycle();
        check("t5_state", 32'(state), 32'd2);
        set_port(1, 0, 0, 1, 8'h70, 16'h0);
        rst = 1'b1;
        #1 check("t5_rvalid1", 32'(p1_rvalid), 32'd0);
        cycle();
        rst = 1'b0;
        check("t5_state_idle", 32'(state), 32'd0);
        set_port(0, 1, 0, 0, 8'h71, 16'h0);
        set_port(1, 1, 0, 0, 8'h72, 16'h0);
        cycle();
        check("t5_og0", 32'(og[0]), 32'd1);

        // read, write, read of one address back to back
        old5 = ref_mem[8'h05];
        set_port(1, 0, 0, 0, 8'h00, 16'h0);
        set_port(0, 1, 0, 0, 8'h05, 16'h0);
        cycle();
        check("t6_old", 32'(p0_rdata), 32'(old5));
        set_port(0, 0, 0, 0, 8'h00, 16'h0);
        set_port(1, 1, 1, 0, 8'h05, 16'h0F0F);
        cycle();
        set_port(1, 0, 0, 0, 8'h00, 16'h0);
        set_port(0, 1, 0, 0, 8'h05, 16'h0);
        cycle();
        check("t6_new", 32'(p0_rdata), 32'h0F0F);
        set_port(0, 0, 0, 0, 8'h00, 16'h0);
        cycle();

        // randomized traffic; commands held until granted
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!req[n] || og[n])
                    set_port(n, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                             ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 15)),
                             DW'($urandom));
            end
            rst = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
